// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and FSM encoding for the systolic array feeder.
package systolic_pkg;
    localparam int N          = 4;
    localparam int DATA_W     = 32;
    localparam int STREAM_LEN = 3 * N - 2;
    localparam int IDX_W      = $clog2(2 * N);
    localparam int STEP_W     = $clog2(STREAM_LEN);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
endpackage

// File: rtl/systolic_feeder_regfile.sv
// systolic_feeder_regfile: 16-entry operand store, one write port, N combinational read taps.
//   clk_i/rst_i      clock, synchronous active-high clear of every entry
//   i_wr_en/addr/data  single write port
//   i_rd_addr[k] -> o_rd_data[k]  combinational read taps
module systolic_feeder_regfile
    import systolic_pkg::*;
#(
    parameter int W = DATA_W
)(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_wr_en,
    input  logic [3:0]   i_wr_addr,
    input  logic [W-1:0] i_wr_data,
    input  logic [3:0]   i_rd_addr [N],
    output logic [W-1:0] o_rd_data [N]
);
    logic [W-1:0] r_mem [16];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) o_rd_data[i] = r_mem[i_rd_addr[i]];
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: stores A/B and streams them diagonally skewed into a 4x4 systolic array.
//   wr_*      operand writes (IDLE only), wr_sel_i 0=A 1=B, addr = row*4+col
//   start_i   begins a 10-step stream when idle and not writing
//   left_o_*  A rows delayed by row index, up_o_* B columns delayed by column index
//   busy_o    high in STREAM and DONE, done_o one-cycle pulse after the stream
module systolic_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 32
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              wr_sel_i,
    input  logic [3:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] left_o_0,
    output logic [DATA_W-1:0] left_o_4,
    output logic [DATA_W-1:0] left_o_8,
    output logic [DATA_W-1:0] left_o_12,
    output logic [DATA_W-1:0] up_o_0,
    output logic [DATA_W-1:0] up_o_1,
    output logic [DATA_W-1:0] up_o_2,
    output logic [DATA_W-1:0] up_o_3,
    output logic              done_o
);
    import systolic_pkg::state_t;
    import systolic_pkg::S_IDLE;
    import systolic_pkg::S_STREAM;
    import systolic_pkg::S_DONE;
    import systolic_pkg::STREAM_LEN;
    import systolic_pkg::STEP_W;

    state_t              r_state, w_state_nxt;
    logic [STEP_W-1:0]   r_t, w_t_nxt;
    logic                r_busy, r_done;
    logic [DATA_W-1:0]   r_left [N];
    logic [DATA_W-1:0]   r_up   [N];
    logic [3:0]          w_a_addr [N];
    logic [3:0]          w_b_addr [N];
    logic [DATA_W-1:0]   w_a_rd [N];
    logic [DATA_W-1:0]   w_b_rd [N];
    logic [N-1:0]        w_ok;
    logic                w_wr;

    assign w_wr = wr_en_i && (r_state == S_IDLE);

    systolic_feeder_regfile #(.W(DATA_W)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .i_wr_en(w_wr && !wr_sel_i), .i_wr_addr(wr_addr_i),
        .i_wr_data(wr_data_i), .i_rd_addr(w_a_addr), .o_rd_data(w_a_rd)
    );

    systolic_feeder_regfile #(.W(DATA_W)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .i_wr_en(w_wr && wr_sel_i), .i_wr_addr(wr_addr_i),
        .i_wr_data(wr_data_i), .i_rd_addr(w_b_addr), .o_rd_data(w_b_rd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        if (r_state == S_IDLE && start_i && !wr_en_i) begin
            w_state_nxt = S_STREAM;
            w_t_nxt     = '0;
        end else if (r_state == S_STREAM) begin
            w_state_nxt = (r_t == STEP_W'(STREAM_LEN - 1)) ? S_DONE : S_STREAM;
            w_t_nxt     = (r_t == STEP_W'(STREAM_LEN - 1)) ? '0 : r_t + 1'b1;
        end else if (r_state == S_DONE) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Outputs are registered, so the taps look up the step about to be entered.
    // Lane k carries element index d = t-k, valid only for t >= k and d <= 3.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [3:0] w_d;
        assign w_d         = w_t_nxt - 4'(k);
        assign w_ok[k]     = (w_state_nxt == S_STREAM) && (w_t_nxt >= 4'(k)) && (w_d <= 4'd3);
        assign w_a_addr[k] = {2'(k), w_d[1:0]};
        assign w_b_addr[k] = {w_d[1:0], 2'(k)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_left[i] <= '0;
                r_up[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_busy  <= w_state_nxt != S_IDLE;
            r_done  <= w_state_nxt == S_DONE;
            for (int i = 0; i < N; i++) begin
                r_left[i] <= w_ok[i] ? w_a_rd[i] : '0;
                r_up[i]   <= w_ok[i] ? w_b_rd[i] : '0;
            end
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign left_o_0  = r_left[0];
    assign left_o_4  = r_left[1];
    assign left_o_8  = r_left[2];
    assign left_o_12 = r_left[3];
    assign up_o_0    = r_up[0];
    assign up_o_1    = r_up[1];
    assign up_o_2    = r_up[2];
    assign up_o_3    = r_up[3];
endmodule
